// File: rtl/uart_word_tx.sv
// Serialises a 32-bit word as up to four 8N1 UART frames, byte 0 first,
// skipping bytes whose group-disable bit is set.
module uart_word_tx #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        stb_i,
    input  logic [31:0] d_i,
    input  logic [3:0]  dis_grp_i,
    output logic        rdy_o,
    output logic        tx_o
);

    localparam int TW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state_reg, state_next;
    logic [31:0]    word_reg, word_next;
    logic [3:0]     mask_reg, mask_next;
    logic [3:0]     sent_reg, sent_next;
    logic [1:0]     sel_reg, sel_next;
    logic [7:0]     byte_reg, byte_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic           rdy_reg, rdy_next;
    logic           tx_reg, tx_next;

    logic [7:0]     word_byte [4];
    logic [3:0]     pending;
    logic           pick_valid;
    logic [1:0]     pick_idx;
    logic           bit_end;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_byte[gi] = word_reg[8*gi +: 8];
        end
    endgenerate

    assign pending = ~mask_reg & ~sent_reg;
    assign bit_end = (timer_reg == T_LAST);

    // Lowest-index pending byte wins; scanning downward lets lower indices overwrite.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) begin
                pick_valid = 1'b1;
                pick_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        word_next    = word_reg;
        mask_next    = mask_reg;
        sent_next    = sent_reg;
        sel_next     = sel_reg;
        byte_next    = byte_reg;
        timer_next   = timer_reg;
        bit_idx_next = bit_idx_reg;

        case (state_reg)
            IDLE: begin
                if (stb_i) begin
                    word_next  = d_i;
                    mask_next  = dis_grp_i;
                    sent_next  = 4'd0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (pick_valid) begin
                    sel_next   = pick_idx;
                    byte_next  = word_byte[pick_idx];
                    timer_next = '0;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_next   = '0;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_next         = '0;
                    sent_next[sel_reg] = 1'b1;
                    state_next         = LOAD;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        rdy_next = (state_next == IDLE);

        // Line level is registered from the current state, so it trails the FSM by one cycle.
        case (state_reg)
            START:   tx_next = 1'b0;
            DATA:    tx_next = byte_reg[bit_idx_reg];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_reg   <= IDLE;
            word_reg    <= 32'd0;
            mask_reg    <= 4'd0;
            sent_reg    <= 4'd0;
            sel_reg     <= 2'd0;
            byte_reg    <= 8'd0;
            timer_reg   <= '0;
            bit_idx_reg <= 3'd0;
            rdy_reg     <= 1'b1;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            word_reg    <= word_next;
            mask_reg    <= mask_next;
            sent_reg    <= sent_next;
            sel_reg     <= sel_next;
            byte_reg    <= byte_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            rdy_reg     <= rdy_next;
            tx_reg      <= tx_next;
        end
    end

    assign rdy_o = rdy_reg;
    assign tx_o  = tx_reg;

endmodule

// File: tb/tb_uart_word_tx.sv
// Scoreboard bench for uart_word_tx: words push expected bytes, a mid-bit
// UART receiver pops and compares every frame.
module tb_uart_word_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] d = 32'd0;
    logic [3:0]  dis = 4'd0;
    logic        rdy;
    logic        tx;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  exp_q [$];
    bit          mon_abort = 1'b0;

    uart_word_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk_i     (clk),
        .rst_in    (rst_n),
        .stb_i     (stb),
        .d_i       (d),
        .dis_grp_i (dis),
        .rdy_o     (rdy),
        .tx_o      (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Receiver: start detected on a falling line, then every bit sampled mid-cell.
    initial begin : monitor
        logic       prev;
        logic [7:0] rx;
        logic       start_bit;
        logic       stop_bit;
        logic [7:0] exp_b;
        prev = 1'b1;
        forever begin
            step(1);
            if (rst_n && prev && !tx) begin
                step(CPB / 2);
                start_bit = tx;
                for (int k = 0; k < 8; k++) begin
                    step(CPB);
                    rx[k] = tx;
                end
                step(CPB);
                stop_bit = tx;
                if (mon_abort) begin
                    mon_abort = 1'b0;
                    $display("frame cut by reset at cycle %0d, discarded", cyc);
                end else begin
                    n_checks++;
                    if (start_bit !== 1'b0)
                        $display("FAIL start_bit: got %b want 0 (cycle %0d)", start_bit, cyc);
                    else
                        n_pass++;
                    n_checks++;
                    if (stop_bit !== 1'b1)
                        $display("FAIL stop_bit: got %b want 1 (cycle %0d)", stop_bit, cyc);
                    else
                        n_pass++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL unexpected_frame: got %02h want none (cycle %0d)", rx, cyc);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (rx !== exp_b)
                            $display("FAIL frame_data: got %02h want %02h (cycle %0d)", rx, exp_b, cyc);
                        else
                            n_pass++;
                    end
                    $display("frame rx=%02h stop=%b at cycle %0d", rx, stop_bit, cyc);
                end
                prev = 1'b1;
            end else begin
                prev = tx;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic send_word(input logic [31:0] w, input logic [3:0] m, output int acc);
        n_checks++;
        if (rdy !== 1'b1)
            $display("FAIL rdy_before_accept: got %b want 1", rdy);
        else
            n_pass++;
        stb = 1'b1;
        d   = w;
        dis = m;
        for (int k = 0; k < 4; k++)
            if (!m[k]) exp_q.push_back(w[8*k +: 8]);
        step(1);
        acc = cyc;
        stb = 1'b0;
        d   = $urandom;
        dis = 4'($urandom);
        $display("word %08h mask %b accepted at cycle %0d", w, m, acc);
        n_checks++;
        if (rdy !== 1'b0)
            $display("FAIL rdy_after_accept: got %b want 0", rdy);
        else
            n_pass++;
    endtask

    task automatic wait_rdy(input int acc, input int want_lat, input string name);
        int n;
        n = 0;
        while (rdy !== 1'b1 && n < 1000) begin
            step(1);
            n++;
        end
        n_checks++;
        if (rdy !== 1'b1)
            $display("FAIL %s: rdy never rose, want latency %0d", name, want_lat);
        else if (cyc - acc != want_lat)
            $display("FAIL %s: rdy latency got %0d want %0d", name, cyc - acc, want_lat);
        else
            n_pass++;
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_frames_left: got %0d want 0", name, exp_q.size());
        else
            n_pass++;
    endtask

    task automatic check_fall(input string name);
        n_checks++;
        if (tx !== 1'b1)
            $display("FAIL %s_tx_load: got %b want 1", name, tx);
        else
            n_pass++;
        step(1);
        n_checks++;
        if (tx !== 1'b0)
            $display("FAIL %s_tx_fall: got %b want 0", name, tx);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        step(3);
        n_checks++;
        if (rdy !== 1'b1 || tx !== 1'b1)
            $display("FAIL reset_hold: got rdy=%b tx=%b want 1/1", rdy, tx);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        n_checks++;
        if (rdy !== 1'b1 || tx !== 1'b1)
            $display("FAIL reset_release: got rdy=%b tx=%b want 1/1", rdy, tx);
        else
            n_pass++;
    endtask

    task automatic test_full_word();
        int acc;
        send_word(32'h44332211, 4'h0, acc);
        step(1);
        check_fall("full");
        wait_rdy(acc, 4 * (10 * CPB + 1) + 1, "full_rdy");
    endtask

    task automatic test_masked();
        int acc;
        send_word(32'hA5C3_0F81, 4'b1010, acc);
        step(1);
        check_fall("masked");
        wait_rdy(acc, 2 * (10 * CPB + 1) + 1, "masked_rdy");
    endtask

    task automatic test_all_disabled();
        int  acc;
        bit  saw_low;
        send_word(32'hCAFE_F00D, 4'hF, acc);
        step(1);
        n_checks++;
        if (rdy !== 1'b1)
            $display("FAIL all_masked_rdy: got %b want 1", rdy);
        else
            n_pass++;
        saw_low = 1'b0;
        for (int i = 0; i < 12 * CPB; i++) begin
            if (tx !== 1'b1) saw_low = 1'b1;
            step(1);
        end
        n_checks++;
        if (saw_low)
            $display("FAIL all_masked_tx: got low pulse want constant 1");
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc, acc2, rise, n;
        n_checks++;
        if (rdy !== 1'b1)
            $display("FAIL b2b_rdy_before: got %b want 1", rdy);
        else
            n_pass++;
        stb = 1'b1;
        d   = 32'hDEADBEEF;
        dis = 4'h0;
        for (int k = 0; k < 4; k++) exp_q.push_back(d[8*k +: 8]);
        step(1);
        acc = cyc;
        $display("word deadbeef mask 0000 accepted at cycle %0d (strobe held)", acc);
        n = 0;
        while (rdy !== 1'b1 && n < 1000) begin
            d   = $urandom;
            dis = 4'($urandom);
            step(1);
            n++;
        end
        rise = cyc;
        n_checks++;
        if (rdy !== 1'b1 || rise - acc != 4 * (10 * CPB + 1) + 1)
            $display("FAIL b2b_busy_rdy: got rdy=%b latency %0d want 1/%0d", rdy, rise - acc,
                     4 * (10 * CPB + 1) + 1);
        else
            n_pass++;
        d   = 32'h12345678;
        dis = 4'b1011;
        exp_q.push_back(8'h34);
        step(1);
        acc2 = cyc;
        stb  = 1'b0;
        $display("word 12345678 mask 1011 accepted at cycle %0d", acc2);
        n_checks++;
        if (rdy !== 1'b0)
            $display("FAIL b2b_second_accept: got rdy=%b want 0", rdy);
        else
            n_pass++;
        wait_rdy(acc2, 10 * CPB + 2, "b2b_rdy");
    endtask

    task automatic test_reset_mid();
        int acc;
        send_word(32'h55AA33CC, 4'h0, acc);
        // Land inside the data bits of byte 1.
        step(54);
        mon_abort = 1'b1;
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || rdy !== 1'b1)
            $display("FAIL midreset_async: got tx=%b rdy=%b want 1/1", tx, rdy);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step(40);
        send_word(32'h000000FF, 4'hE, acc);
        step(1);
        check_fall("post_reset");
        wait_rdy(acc, 10 * CPB + 2, "post_reset_rdy");
    endtask

    initial begin : main
        test_reset();
        test_full_word();
        test_masked();
        test_all_disabled();
        test_back_to_back();
        test_reset_mid();
        step(10);
        n_checks++;
        if (exp_q.size() != 0 || mon_abort)
            $display("FAIL final_scoreboard: got %0d pending abort=%b want 0/0", exp_q.size(), mon_abort);
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
